reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//  Shares the 12-bit hardware register port (index 0xF000-0xFFFF window) between NUM_REQ
//  requesters, e.g. lisp_core data port (req 0) and a debug/host port (req 1+).
//  Grants at most one access per cycle, returns read data one cycle after issue, and
//  supports a bounded bus lock for atomic read-modify-write sequences on peripherals.
// PARAMETERS
//  NUM_REQ       2    number of requesters, 2..8
//  PRIORITY0     1    1: req 0 wins every unlocked cycle (core never stalls); 0: pure round-robin
//  LOCK_TIMEOUT  64   max cycles a lock is held before forced release; 0 disables timeout
// PORTS
//  clk                   in   1            system clock
//  reset_n               in   1            synchronous, active-low reset
//  req_valid             in   NUM_REQ      requester i wants an access; held stable until gnt[i]
//  req_write             in   NUM_REQ      1 write, 0 read
//  req_lock              in   NUM_REQ      request/keep exclusive ownership after this access
//  req_index             in   12*NUM_REQ   register index, slice [12*i+:12]
//  req_wdata             in   16*NUM_REQ   write data, slice [16*i+:16]
//  gnt                   out  NUM_REQ      one-hot, access issued this cycle
//  rsp_valid             out  NUM_REQ      one-hot, read data for requester i on rsp_rdata
//  rsp_rdata             out  16           read data, shared by all requesters
//  lock_timeout          out  1            pulses 1 cycle when a lock is force-released
//  register_index        out  12           to peripherals
//  register_read         out  1            read strobe
//  register_write        out  1            write strobe
//  register_write_value  out  16           write data
//  register_read_value   in   16           valid the cycle after register_read
// BEHAVIOUR
//  - Reset: gnt, rsp_valid, register_read/write, lock_timeout = 0; index/wdata = 0;
//    rr_ptr = NUM_REQ-1 (req 0 searched first); no owner; lock counter = 0.
//  - Arbitration is combinational on req_valid; bus strobes and gnt are same-cycle
//    (no added latency), so register_* = selected requester's fields, strobe = |gnt.
//  - Selection order: (1) lock owner, if any: only owner may be granted, others wait;
//    (2) else if PRIORITY0 && req_valid[0]: req 0; (3) else first valid from rr_ptr+1 upward,
//    wrapping at NUM_REQ. rr_ptr <= granted index on every grant (not on owner-only grants).
//  - Read response: rsp_valid[i] registered = read granted to i in previous cycle;
//    rsp_rdata = register_read_value (pass-through). Writes produce no response.
//  - Back-to-back reads from different requesters in consecutive cycles allowed.
//  - Lock FSM: UNLOCKED -> LOCKED(owner=i) when gnt[i] && req_lock[i].
//    LOCKED -> UNLOCKED when owner is granted with req_lock[i]=0, or owner drops req_valid
//    and req_lock together, or counter reaches LOCK_TIMEOUT (lock_timeout pulse, owner's
//    pending access not granted that cycle, rr_ptr <= owner). Counter counts every LOCKED cycle,
//    clears on entry.
//  - Owner idle while locked (req_valid=0, req_lock=1): bus idles, no grants.
//  - Reset mid-operation: pending rsp_valid dropped, lock cleared; requesters must reissue.
//  - gnt never asserted for a requester with req_valid=0; never more than one bit set.
// STRUCTURE
//  - Shared package reg_bus_pkg: REG_INDEX_W=12, REG_DATA_W=16, HW_REG_PREFIX=4'hF.
//  - One sub-module: rr_pick (NUM_REQ-wide rotate/priority-encode from pointer, combinational).
//  - Top holds rr_ptr, lock owner/counter FSM, response pipeline register.
// TESTING
//  - Reset: hold reset_n=0 with all req_valid=1 -> gnt=0, strobes 0; release -> gnt=01 first.
//  - PRIORITY0=0, both request reads each cycle -> gnt alternates 01,10,01..; rsp_valid
//    follows one cycle later, rsp_rdata = stubbed value for 0xF004 (e.g. 16'h1234).
//  - PRIORITY0=1, req 1 write 0x010<-16'hBEEF while req 0 continuously valid -> req 1 starved;
//    req 0 idles one cycle -> req 1 granted, register_write=1, value 16'hBEEF.
//  - Lock: req 1 read 0x020 with lock, then write 0x020 without lock; req 0 valid throughout
//    -> req 0 blocked exactly between the two grants, granted next cycle.
//  - Timeout: LOCK_TIMEOUT=4, req 1 locks and idles -> lock_timeout pulse 4 cycles after entry,
//    req 0 granted following cycle.
//  - Reset asserted the cycle after a read grant -> no rsp_valid emitted.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the hardware register bus (0xF000-0xFFFF window).
// Holds bus widths, the window prefix and the lock FSM state type.
package reg_bus_pkg;

  localparam int unsigned REG_INDEX_W   = 12;
  localparam int unsigned REG_DATA_W    = 16;
  localparam logic [3:0]  HW_REG_PREFIX = 4'hF;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_e;

endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req starting at ptr+1 upward, wrapping at NUM_REQ; ptr itself is
// searched last.
//   req   : request vector
//   ptr   : index of the most recent winner
//   found : some request is set
//   idx   : index of the first set request in rotated order
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares the 12-bit hardware register port between NUM_REQ
// requesters. One access per cycle, granted combinationally; read data is
// returned one cycle after issue. A requester may take a bounded exclusive
// lock for read-modify-write sequences.
//   req_valid/write/lock/index/wdata : per-requester access request
//   gnt                              : one-hot, access issued this cycle
//   rsp_valid / rsp_rdata            : read response for requester i
//   lock_timeout                     : 1-cycle pulse on forced lock release
//   register_*                       : peripheral bus
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned PRIORITY0    = 1,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [REG_INDEX_W*NUM_REQ-1:0] req_index,
  input  logic [REG_DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [REG_DATA_W-1:0]          rsp_rdata,
  output logic                           lock_timeout,
  output logic [REG_INDEX_W-1:0]         register_index,
  output logic                           register_read,
  output logic                           register_write,
  output logic [REG_DATA_W-1:0]          register_write_value,
  input  logic [REG_DATA_W-1:0]          register_read_value
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  lock_state_e          state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   rsp_q, rsp_d;
  logic                 lock_timeout_q, lock_timeout_d;

  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx;
  logic                 grant;
  logic [IDX_W-1:0]     sel_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Selection: lock owner only, else fixed-priority req 0, else round-robin.
  // Nothing is granted while reset_n is low or in a forced-release cycle.
  always_comb begin
    grant   = 1'b0;
    sel_idx = '0;
    if (reset_n) begin
      if (state_q == LOCK_HELD) begin
        if (!lock_timeout_q && req_valid[owner_q]) begin
          grant   = 1'b1;
          sel_idx = owner_q;
        end
      end else if (PRIORITY0 != 0 && req_valid[0]) begin
        grant   = 1'b1;
        sel_idx = '0;
      end else if (rr_found) begin
        grant   = 1'b1;
        sel_idx = rr_idx;
      end
    end
  end

  always_comb begin
    gnt                  = '0;
    rsp_d                = '0;
    register_index       = '0;
    register_write_value = '0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant && sel_idx == IDX_W'(i)) begin
        gnt[i]               = 1'b1;
        rsp_d[i]             = !req_write[i];
        register_index       = req_index[REG_INDEX_W*i +: REG_INDEX_W];
        register_write_value = req_wdata[REG_DATA_W*i +: REG_DATA_W];
        register_read        = !req_write[i];
        register_write       = req_write[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == LOCK_IDLE) begin
      if (grant) begin
        rr_ptr_d = sel_idx;
        if (req_lock[sel_idx]) begin
          state_d = LOCK_HELD;
          owner_d = sel_idx;
          cnt_d   = '0;
        end
      end
    end else begin
      if (lock_timeout_q) begin
        state_d  = LOCK_IDLE;
        rr_ptr_d = owner_q;
        cnt_d    = '0;
      end else if (!req_lock[owner_q]) begin
        // Outside a forced release the owner is granted exactly when valid, so
        // "granted without lock" and "dropped valid and lock" both reduce to
        // the owner's lock bit being low.
        state_d = LOCK_IDLE;
        cnt_d   = '0;
      end else if (LOCK_TIMEOUT != 0 && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Flag the cycle in which the counter sits at the limit; that cycle is
    // the forced-release cycle.
    lock_timeout_d = (LOCK_TIMEOUT != 0) && (state_d == LOCK_HELD) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= LOCK_IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= IDX_W'(NUM_REQ - 1);
      cnt_q          <= '0;
      rsp_q          <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      rsp_q          <= rsp_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign rsp_valid    = reset_n ? rsp_q : '0;
  assign lock_timeout = reset_n & lock_timeout_q;
  assign rsp_rdata    = register_read_value;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_write, req_lock;
  logic [23:0] req_index;
  logic [31:0] req_wdata;
  logic [15:0] rd_val = 16'h0000;

  logic [1:0]  rr_gnt, rr_rsp, pri_gnt, pri_rsp, to_gnt, to_rsp;
  logic [15:0] rr_rdata, pri_rdata, to_rdata, rr_wval, pri_wval, to_wval;
  logic [11:0] rr_index, pri_index, to_index;
  logic        rr_rd, rr_wr, pri_rd, pri_wr, to_rd, to_wr;
  logic        rr_lto, pri_lto, to_lto;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.NUM_REQ(2), .PRIORITY0(0), .LOCK_TIMEOUT(64)) u_rr (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_lock(req_lock), .req_index(req_index), .req_wdata(req_wdata),
    .gnt(rr_gnt), .rsp_valid(rr_rsp), .rsp_rdata(rr_rdata), .lock_timeout(rr_lto),
    .register_index(rr_index), .register_read(rr_rd), .register_write(rr_wr),
    .register_write_value(rr_wval), .register_read_value(rd_val));

  reg_bus_arbiter #(.NUM_REQ(2), .PRIORITY0(1), .LOCK_TIMEOUT(64)) u_pri (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_lock(req_lock), .req_index(req_index), .req_wdata(req_wdata),
    .gnt(pri_gnt), .rsp_valid(pri_rsp), .rsp_rdata(pri_rdata), .lock_timeout(pri_lto),
    .register_index(pri_index), .register_read(pri_rd), .register_write(pri_wr),
    .register_write_value(pri_wval), .register_read_value(rd_val));

  reg_bus_arbiter #(.NUM_REQ(2), .PRIORITY0(1), .LOCK_TIMEOUT(4)) u_to (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_lock(req_lock), .req_index(req_index), .req_wdata(req_wdata),
    .gnt(to_gnt), .rsp_valid(to_rsp), .rsp_rdata(to_rdata), .lock_timeout(to_lto),
    .register_index(to_index), .register_read(to_rd), .register_write(to_wr),
    .register_write_value(to_wval), .register_read_value(rd_val));

  // Peripheral stub on the round-robin instance's bus: 0x004 -> 1234, 0x008 -> 5678.
  always @(posedge clk) begin
    if (rr_rd && rr_index == 12'h004)      rd_val <= 16'h1234;
    else if (rr_rd && rr_index == 12'h008) rd_val <= 16'h5678;
    else if (rr_rd)                        rd_val <= 16'hDEAD;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_lock  = 2'b00;
    req_index = '0;
    req_wdata = '0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_lock  = 2'b00;
    req_index = {12'h008, 12'h004};
    req_wdata = {16'h5555, 16'hAAAA};
    repeat (2) step();
    #1;
    n_cmp++; if ({rr_gnt, pri_gnt, to_gnt} !== 6'b0) begin n_err++;
      $display("FAIL reset_gnt: got %b want 000000", {rr_gnt, pri_gnt, to_gnt}); end
    n_cmp++; if ({rr_rsp, pri_rsp, to_rsp} !== 6'b0) begin n_err++;
      $display("FAIL reset_rsp_valid: got %b want 000000", {rr_rsp, pri_rsp, to_rsp}); end
    n_cmp++; if ({rr_rd, rr_wr, pri_rd, pri_wr, to_rd, to_wr} !== 6'b0) begin n_err++;
      $display("FAIL reset_strobes: got %b want 000000", {rr_rd, rr_wr, pri_rd, pri_wr, to_rd, to_wr}); end
    n_cmp++; if ({rr_lto, pri_lto, to_lto} !== 3'b0) begin n_err++;
      $display("FAIL reset_lock_timeout: got %b want 000", {rr_lto, pri_lto, to_lto}); end
    n_cmp++; if ({rr_index, pri_index, to_index} !== 36'h0) begin n_err++;
      $display("FAIL reset_index: got %h want 0", {rr_index, pri_index, to_index}); end
    n_cmp++; if ({rr_wval, pri_wval, to_wval} !== 48'h0) begin n_err++;
      $display("FAIL reset_wdata: got %h want 0", {rr_wval, pri_wval, to_wval}); end
    n_cmp++; if ({rr_rdata, pri_rdata, to_rdata} !== {rd_val, rd_val, rd_val}) begin n_err++;
      $display("FAIL reset_rdata_passthru: got %h want %h x3", {rr_rdata, pri_rdata, to_rdata}, rd_val); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if ({rr_gnt, pri_gnt, to_gnt} !== 6'b010101) begin n_err++;
      $display("FAIL reset_release_gnt: got %b want 010101", {rr_gnt, pri_gnt, to_gnt}); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0]  exp_rsp [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
    logic [15:0] exp_dat [4] = '{16'h0000, 16'h1234, 16'h5678, 16'h1234};
    logic [11:0] exp_idx [4] = '{12'h004, 12'h008, 12'h004, 12'h008};
    apply_reset();
    req_valid = 2'b11;
    req_index = {12'h008, 12'h004};
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (rr_gnt !== exp_gnt[c] || rr_rd !== 1'b1 || rr_index !== exp_idx[c]) begin n_err++;
        $display("FAIL rr_grant c%0d: got gnt=%b rd=%b idx=%h want gnt=%b rd=1 idx=%h",
                 c, rr_gnt, rr_rd, rr_index, exp_gnt[c], exp_idx[c]); end
      n_cmp++; if (rr_rsp !== exp_rsp[c]) begin n_err++;
        $display("FAIL rr_rsp_valid c%0d: got %b want %b", c, rr_rsp, exp_rsp[c]); end
      if (c > 0) begin
        n_cmp++; if (rr_rdata !== exp_dat[c]) begin n_err++;
          $display("FAIL rr_rdata c%0d: got %h want %h", c, rr_rdata, exp_dat[c]); end
      end
      step();
    end
  endtask

  task automatic test_priority0();
    apply_reset();
    req_valid = 2'b11;
    req_write = 2'b10;
    req_index = {12'h010, 12'h001};
    req_wdata = {16'hBEEF, 16'h0000};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (pri_gnt !== 2'b01 || pri_rd !== 1'b1 || pri_wr !== 1'b0) begin n_err++;
        $display("FAIL pri_starve c%0d: got gnt=%b rd=%b wr=%b want 01 1 0", c, pri_gnt, pri_rd, pri_wr); end
      step();
    end
    req_valid = 2'b10;
    #1;
    n_cmp++; if (pri_gnt !== 2'b10 || pri_wr !== 1'b1 || pri_rd !== 1'b0) begin n_err++;
      $display("FAIL pri_req1_gnt: got gnt=%b wr=%b rd=%b want 10 1 0", pri_gnt, pri_wr, pri_rd); end
    n_cmp++; if (pri_index !== 12'h010 || pri_wval !== 16'hBEEF) begin n_err++;
      $display("FAIL pri_req1_bus: got idx=%h val=%h want 010 beef", pri_index, pri_wval); end
    step();
    req_valid = 2'b00;
    #1;
    n_cmp++; if (pri_gnt !== 2'b00 || pri_wr !== 1'b0) begin n_err++;
      $display("FAIL pri_idle: got gnt=%b wr=%b want 00 0", pri_gnt, pri_wr); end
    step();
  endtask

  task automatic test_lock();
    apply_reset();
    req_valid = 2'b11;
    req_lock  = 2'b10;
    req_index = {12'h020, 12'h004};
    #1;
    n_cmp++; if (rr_gnt !== 2'b01) begin n_err++;
      $display("FAIL lock_first: got %b want 01", rr_gnt); end
    step();
    #1;
    n_cmp++; if (rr_gnt !== 2'b10 || rr_rd !== 1'b1 || rr_index !== 12'h020) begin n_err++;
      $display("FAIL lock_take: got gnt=%b rd=%b idx=%h want 10 1 020", rr_gnt, rr_rd, rr_index); end
    step();
    req_valid = 2'b01;
    #1;
    n_cmp++; if (rr_gnt !== 2'b00) begin n_err++;
      $display("FAIL lock_block: got %b want 00", rr_gnt); end
    n_cmp++; if (rr_rsp !== 2'b10) begin n_err++;
      $display("FAIL lock_rsp: got %b want 10", rr_rsp); end
    step();
    req_valid = 2'b11;
    req_write = 2'b10;
    req_lock  = 2'b00;
    req_wdata = {16'h00AA, 16'h0000};
    #1;
    n_cmp++; if (rr_gnt !== 2'b10 || rr_wr !== 1'b1 || rr_index !== 12'h020 || rr_wval !== 16'h00AA) begin n_err++;
      $display("FAIL lock_release_wr: got gnt=%b wr=%b idx=%h val=%h want 10 1 020 00aa",
               rr_gnt, rr_wr, rr_index, rr_wval); end
    step();
    req_valid = 2'b01;
    req_write = 2'b00;
    #1;
    n_cmp++; if (rr_gnt !== 2'b01) begin n_err++;
      $display("FAIL lock_after: got %b want 01", rr_gnt); end
    step();
  endtask

  task automatic test_timeout();
    apply_reset();
    req_valid = 2'b10;
    req_lock  = 2'b10;
    req_index = {12'h030, 12'h004};
    #1;
    n_cmp++; if (to_gnt !== 2'b10) begin n_err++;
      $display("FAIL to_take: got %b want 10", to_gnt); end
    step();
    req_valid = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_cmp++; if (to_gnt !== 2'b00 || to_lto !== 1'b0) begin n_err++;
        $display("FAIL to_held c%0d: got gnt=%b lto=%b want 00 0", c, to_gnt, to_lto); end
      step();
    end
    #1;
    n_cmp++; if (to_gnt !== 2'b00 || to_lto !== 1'b1) begin n_err++;
      $display("FAIL to_pulse: got gnt=%b lto=%b want 00 1", to_gnt, to_lto); end
    step();
    #1;
    n_cmp++; if (to_gnt !== 2'b01 || to_lto !== 1'b0) begin n_err++;
      $display("FAIL to_after: got gnt=%b lto=%b want 01 0", to_gnt, to_lto); end
    step();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    req_valid = 2'b01;
    req_index = {12'h000, 12'h004};
    #1;
    n_cmp++; if (rr_gnt !== 2'b01) begin n_err++;
      $display("FAIL rst_mid_gnt: got %b want 01", rr_gnt); end
    step();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    #1;
    n_cmp++; if (rr_rsp !== 2'b00) begin n_err++;
      $display("FAIL rst_mid_rsp0: got %b want 00", rr_rsp); end
    step();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (rr_rsp !== 2'b00) begin n_err++;
      $display("FAIL rst_mid_rsp1: got %b want 00", rr_rsp); end
    step();
    #1;
    n_cmp++; if (rr_rsp !== 2'b00 || rr_gnt !== 2'b00) begin n_err++;
      $display("FAIL rst_mid_rsp2: got rsp=%b gnt=%b want 00 00", rr_rsp, rr_gnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority0();
    test_lock();
    test_timeout();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
